bp_dram_dma_arbiter: RTL and testbench
======================================

Name: bp_dram_dma_arbiter

Overview:
- Shares the single bsg_cache DMA port of mig_ddr3_ram between num_req_p DMA requesters (e.g. the unicore L2 and a host-side loader/scrubber).
- Round-robin arbitration with one outstanding transaction: a grant is held from packet issue until the last data beat of that transaction.
- Blocks all grants until DRAM calibration completes.
- Sits in the core clock domain, between the requesters and the dram_controller DMA ports.

Parameters:
- num_req_p, 2, number of upstream requesters (>=1).
- dma_pkt_width_p, 33, bsg_cache DMA packet width; bit [dma_pkt_width_p-1] is write_not_read.
- data_width_p, 64, DMA data beat width (l2_fill_width_p).
- beats_p, 8, data beats per transaction (block width / fill width; >=1).

Ports:
- clk_i  in  1  core clock.
- reset_i  in  1  synchronous active-high reset.
- init_calib_complete_i  in  1  DRAM calibration done (synchronous to clk_i).
- req_dma_pkt_i  in  num_req_p*dma_pkt_width_p  per-requester packets; requester k occupies slice k.
- req_dma_pkt_v_i  in  num_req_p  packet valid.
- req_dma_pkt_yumi_o  out  num_req_p  packet accepted.
- req_dma_data_o  out  num_req_p*data_width_p  read data to requester (broadcast copy of dram_dma_data_i).
- req_dma_data_v_o  out  num_req_p  read data valid.
- req_dma_data_ready_and_i  in  num_req_p  requester ready for read data.
- req_dma_data_i  in  num_req_p*data_width_p  write data from requesters.
- req_dma_data_v_i  in  num_req_p  write data valid.
- req_dma_data_yumi_o  out  num_req_p  write data consumed.
- dram_dma_pkt_o  out  dma_pkt_width_p  packet to controller.
- dram_dma_pkt_v_o  out  1  packet valid.
- dram_dma_pkt_yumi_i  in  1  controller accepts packet.
- dram_dma_data_i  in  data_width_p  read data from controller.
- dram_dma_data_v_i  in  1  read data valid.
- dram_dma_data_ready_and_o  out  1  ready for read data.
- dram_dma_data_o  out  data_width_p  write data to controller.
- dram_dma_data_v_o  out  1  write data valid.
- dram_dma_data_yumi_i  in  1  controller consumes write data.
- busy_o  out  1  state != IDLE.

Behaviour:
- Reset: state=IDLE; gnt_r=0; rr_ptr_r=0 (requester 0 highest priority); beat_cnt_r=0. All v, yumi, ready and busy outputs are 0 during reset and the cycle after.
- Reset mid-transaction: the transaction is abandoned, state returns to IDLE, and no yumi or ready is asserted while reset_i=1.
- States are IDLE, PKT, WDATA, RDATA.
- IDLE:
  - Transition only when init_calib_complete_i=1 and |req_dma_pkt_v_i.
  - Grant the first valid requester at or after rr_ptr_r, searching upward with wrap.
  - Register it into gnt_r and go to PKT.
  - No outputs are asserted in IDLE; arbitration costs one cycle.
- PKT:
  - dram_dma_pkt_o = slice gnt_r; dram_dma_pkt_v_o = 1 (the requester must hold its valid; the bench checks this).
  - On dram_dma_pkt_yumi_i: assert req_dma_pkt_yumi_o[gnt_r] in the same cycle and latch is_write = pkt MSB.
  - Next state is WDATA if is_write, else RDATA; beat_cnt_r=0.
- WDATA:
  - dram_dma_data_o = slice gnt_r; dram_dma_data_v_o = req_dma_data_v_i[gnt_r]; req_dma_data_yumi_o[gnt_r] = dram_dma_data_yumi_i.
  - Each yumi increments beat_cnt_r.
  - The yumi of beat beats_p-1 goes to IDLE.
- RDATA:
  - req_dma_data_v_o[gnt_r] = dram_dma_data_v_i; dram_dma_data_ready_and_o = req_dma_data_ready_and_i[gnt_r].
  - Each v&ready handshake increments beat_cnt_r.
  - The handshake of beat beats_p-1 goes to IDLE.
- Leaving WDATA or RDATA sets rr_ptr_r = gnt_r+1, wrapping to 0 at num_req_p.
- Non-granted requesters see all their yumi and v outputs at 0 at all times.
- Downstream read data arriving outside RDATA is not acknowledged (ready=0).
- beat_cnt_r width is $clog2(beats_p+1).
- beats_p=1: a single beat completes the transaction.
- num_req_p=1: the arbiter degenerates to a pass-through that keeps the IDLE cycle.
- A requester asserting a new packet while its own transaction is in flight is not granted until IDLE.
- A requester that drops valid between grant and yumi is a protocol violation; assert in simulation.
- An X on init_calib_complete_i during reset is ignored.

Test Plan:
- Calibration gating: init_calib_complete_i=0, req0 read pkt valid 20 cycles -> no dram_dma_pkt_v_o. Raise calib -> pkt_v_o 2 cycles later, pkt equals req0 slice.
- Single read, beats_p=8: req1 pkt addr 0x1000 with MSB=0. Controller returns data 0..7 with ready toggled by req1 -> exactly 8 handshakes. req1 sees the data in order, req0 sees v=0, busy_o falls the cycle after beat 7.
- Single write: req0 pkt MSB=1, data 0xA0..0xA7, controller yumi every other cycle -> dram_dma_data_o order matches. req0 yumi count is 8, then IDLE.
- Fairness: both requesters hold read packets continuously -> grants alternate 0,1,0,1 over 4 transactions. rr_ptr_r sequence is 1,0,1,0.
- Reset mid-write after beat 3: reset_i pulses for 1 cycle -> busy_o=0 and all v/yumi outputs 0. The next transaction starts cleanly with beat_cnt_r=0.
- beats_p=1 config: back-to-back read and write from req1 -> each completes in one beat. The second transaction's packet appears 1 cycle after the first returns to IDLE.

Source files
------------

// File: rtl/bp_dram_dma_arbiter.sv
// bp_dram_dma_arbiter: round-robin share of one bsg_cache DMA port, one transaction in flight, gated by DRAM calibration
//   upstream   : req_dma_pkt_* (packet in), req_dma_data_*_o (read data out), req_dma_data_*_i (write data in)
//   downstream : dram_dma_pkt_* (packet out), dram_dma_data_*_i (read data in), dram_dma_data_*_o (write data out)
//   status     : busy_o is high whenever a transaction owns the port
module bp_dram_dma_arbiter #(
    parameter int num_req_p       = 2,
    parameter int dma_pkt_width_p = 33,
    parameter int data_width_p    = 64,
    parameter int beats_p         = 8
) (
    input  logic                                 clk_i,
    input  logic                                 reset_i,
    input  logic                                 init_calib_complete_i,
    input  logic [num_req_p*dma_pkt_width_p-1:0] req_dma_pkt_i,
    input  logic [num_req_p-1:0]                 req_dma_pkt_v_i,
    output logic [num_req_p-1:0]                 req_dma_pkt_yumi_o,
    output logic [num_req_p*data_width_p-1:0]    req_dma_data_o,
    output logic [num_req_p-1:0]                 req_dma_data_v_o,
    input  logic [num_req_p-1:0]                 req_dma_data_ready_and_i,
    input  logic [num_req_p*data_width_p-1:0]    req_dma_data_i,
    input  logic [num_req_p-1:0]                 req_dma_data_v_i,
    output logic [num_req_p-1:0]                 req_dma_data_yumi_o,
    output logic [dma_pkt_width_p-1:0]           dram_dma_pkt_o,
    output logic                                 dram_dma_pkt_v_o,
    input  logic                                 dram_dma_pkt_yumi_i,
    input  logic [data_width_p-1:0]              dram_dma_data_i,
    input  logic                                 dram_dma_data_v_i,
    output logic                                 dram_dma_data_ready_and_o,
    output logic [data_width_p-1:0]              dram_dma_data_o,
    output logic                                 dram_dma_data_v_o,
    input  logic                                 dram_dma_data_yumi_i,
    output logic                                 busy_o
);
    localparam int iw_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1;
    localparam int sw_lp = iw_lp + 1;
    localparam int cw_lp = $clog2(beats_p + 1);
    localparam logic [iw_lp-1:0] last_req_lp  = iw_lp'(num_req_p - 1);
    localparam logic [sw_lp-1:0] nreq_lp      = sw_lp'(num_req_p);
    localparam logic [cw_lp-1:0] last_beat_lp = cw_lp'(beats_p - 1);
    typedef enum logic [1:0] {IDLE, PKT, WDATA, RDATA} state_e;
    state_e                     state_q, state_d;
    logic [iw_lp-1:0]           gnt_q, gnt_d, rr_q, rr_d, pick, cand, rr_next;
    logic [sw_lp-1:0]           sum;
    logic [cw_lp-1:0]           beat_q, beat_d;
    logic                       found, live, w_hs, r_hs, last;
    logic [dma_pkt_width_p-1:0] gnt_pkt;
    // first valid requester at or after rr_q, searching upward with wrap
    always_comb begin
        pick  = rr_q;
        found = 1'b0;
        sum   = '0;
        cand  = '0;
        for (int i = 0; i < num_req_p; i++) begin
            sum  = {1'b0, rr_q} + sw_lp'(i);
            cand = (sum >= nreq_lp) ? iw_lp'(sum - nreq_lp) : iw_lp'(sum);
            if (!found && req_dma_pkt_v_i[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
    end
    assign gnt_pkt         = req_dma_pkt_i[gnt_q*dma_pkt_width_p +: dma_pkt_width_p];
    assign dram_dma_pkt_o  = gnt_pkt;
    assign dram_dma_data_o = req_dma_data_i[gnt_q*data_width_p +: data_width_p];
    assign req_dma_data_o  = {num_req_p{dram_dma_data_i}};
    assign rr_next         = (gnt_q == last_req_lp) ? '0 : gnt_q + 1'b1;
    assign last            = beat_q == last_beat_lp;
    // every handshake is suppressed while reset is held so an abandoned transaction leaks nothing
    assign live            = !reset_i;
    assign busy_o          = live && state_q != IDLE;
    assign w_hs            = live && state_q == WDATA && dram_dma_data_yumi_i;
    assign r_hs            = dram_dma_data_ready_and_o && dram_dma_data_v_i;
    always_comb begin
        req_dma_pkt_yumi_o             = '0;
        req_dma_data_v_o               = '0;
        req_dma_data_yumi_o            = '0;
        dram_dma_pkt_v_o               = live && state_q == PKT;
        dram_dma_data_v_o              = live && state_q == WDATA && req_dma_data_v_i[gnt_q];
        dram_dma_data_ready_and_o      = live && state_q == RDATA && req_dma_data_ready_and_i[gnt_q];
        req_dma_pkt_yumi_o[gnt_q]      = dram_dma_pkt_v_o && dram_dma_pkt_yumi_i;
        req_dma_data_yumi_o[gnt_q]     = w_hs;
        req_dma_data_v_o[gnt_q]        = live && state_q == RDATA && dram_dma_data_v_i;
    end
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        rr_d    = rr_q;
        beat_d  = beat_q;
        case (state_q)
            IDLE: if (init_calib_complete_i && found) begin
                gnt_d   = pick;
                state_d = PKT;
            end
            PKT: if (dram_dma_pkt_yumi_i) begin
                state_d = gnt_pkt[dma_pkt_width_p-1] ? WDATA : RDATA;
                beat_d  = '0;
            end
            default: if (w_hs || r_hs) begin
                beat_d = beat_q + 1'b1;
                if (last) begin
                    state_d = IDLE;
                    rr_d    = rr_next;
                end
            end
        endcase
    end
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            rr_q    <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            rr_q    <= rr_d;
            beat_q  <= beat_d;
        end
    end
    // a granted requester must keep its packet valid until the controller takes it
    assert property (@(posedge clk_i) disable iff (reset_i) (state_q == PKT) |-> req_dma_pkt_v_i[gnt_q]);
endmodule

// File: tb/tb_bp_dram_dma_arbiter.sv
// tb_bp_dram_dma_arbiter: scoreboard bench for the DMA arbiter (beats 8 and beats 1 instances)
module tb_bp_dram_dma_arbiter;
    localparam int N = 2, PW = 33, DW = 64, B = 8;
    typedef struct {int idx; logic [DW-1:0] val;} exp_t;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    int total = 0, bad = 0;
    logic reset_r, calib_r;
    logic [N*PW-1:0] pkt_r;
    logic [N-1:0]    pkt_v_r, pkt_yumi, rdata_v, rready_r, wdata_v_r, wyumi;
    logic [N*DW-1:0] rdata, wdata_r;
    logic [PW-1:0]   dpkt;
    logic            dpkt_v, dpkt_yumi, ddata_v_in, dready, ddata_v_out, dyumi, busy;
    logic [DW-1:0]   ddata_in_r, ddata_out;
    logic            cq_v_r, stray_r, wtog, rtog;
    logic [PW-1:0]   rq0[$], rq1[$];
    logic [DW-1:0]   wq0[$], wq1[$], cq[$];
    exp_t            ep[$], er[$], ew[$], se[$];
    assign dpkt_yumi  = dpkt_v;
    assign dyumi      = ddata_v_out & wtog;
    assign ddata_v_in = cq_v_r | stray_r;
    bp_dram_dma_arbiter #(.num_req_p(N), .dma_pkt_width_p(PW), .data_width_p(DW), .beats_p(B)) dut (
        .clk_i(clk), .reset_i(reset_r), .init_calib_complete_i(calib_r),
        .req_dma_pkt_i(pkt_r), .req_dma_pkt_v_i(pkt_v_r), .req_dma_pkt_yumi_o(pkt_yumi),
        .req_dma_data_o(rdata), .req_dma_data_v_o(rdata_v), .req_dma_data_ready_and_i(rready_r),
        .req_dma_data_i(wdata_r), .req_dma_data_v_i(wdata_v_r), .req_dma_data_yumi_o(wyumi),
        .dram_dma_pkt_o(dpkt), .dram_dma_pkt_v_o(dpkt_v), .dram_dma_pkt_yumi_i(dpkt_yumi),
        .dram_dma_data_i(ddata_in_r), .dram_dma_data_v_i(ddata_v_in), .dram_dma_data_ready_and_o(dready),
        .dram_dma_data_o(ddata_out), .dram_dma_data_v_o(ddata_v_out), .dram_dma_data_yumi_i(dyumi),
        .busy_o(busy));
    logic [N*PW-1:0] s_pkt;
    logic [N-1:0]    s_pkt_v, s_pkt_yumi, s_rdata_v, s_rready, s_wdata_v, s_wyumi;
    logic [N*DW-1:0] s_rdata, s_wdata;
    logic [PW-1:0]   s_dpkt;
    logic            s_dpkt_v, s_dpkt_yumi, s_ddata_v_in, s_dready, s_ddata_v_out, s_dyumi, s_busy;
    logic [DW-1:0]   s_ddata_in, s_ddata_out;
    assign s_dpkt_yumi  = s_dpkt_v;
    assign s_dyumi      = s_ddata_v_out;
    assign s_ddata_v_in = 1'b1;
    assign s_ddata_in   = 64'h5a5a;
    assign s_rready     = 2'b11;
    assign s_wdata      = {64'hbeef_0001, 64'h0};
    assign s_wdata_v    = 2'b10;
    bp_dram_dma_arbiter #(.num_req_p(N), .dma_pkt_width_p(PW), .data_width_p(DW), .beats_p(1)) dut1 (
        .clk_i(clk), .reset_i(reset_r), .init_calib_complete_i(calib_r),
        .req_dma_pkt_i(s_pkt), .req_dma_pkt_v_i(s_pkt_v), .req_dma_pkt_yumi_o(s_pkt_yumi),
        .req_dma_data_o(s_rdata), .req_dma_data_v_o(s_rdata_v), .req_dma_data_ready_and_i(s_rready),
        .req_dma_data_i(s_wdata), .req_dma_data_v_i(s_wdata_v), .req_dma_data_yumi_o(s_wyumi),
        .dram_dma_pkt_o(s_dpkt), .dram_dma_pkt_v_o(s_dpkt_v), .dram_dma_pkt_yumi_i(s_dpkt_yumi),
        .dram_dma_data_i(s_ddata_in), .dram_dma_data_v_i(s_ddata_v_in), .dram_dma_data_ready_and_o(s_dready),
        .dram_dma_data_o(s_ddata_out), .dram_dma_data_v_o(s_ddata_v_out), .dram_dma_data_yumi_i(s_dyumi),
        .busy_o(s_busy));
    function automatic logic [PW-1:0] mk(input logic w, input logic [31:0] a);
        return {w, a};
    endfunction
    function automatic logic [DW-1:0] rdat(input logic [PW-1:0] p, input int i);
        return {p[31:0], 32'(i)};
    endfunction
    function automatic logic [N-1:0] oh(input int i);
        return N'(1) << i;
    endfunction
    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask
    task automatic extra(input string nm);
        total++;
        bad++;
        $display("FAIL %s got=unexpected-handshake want=none", nm);
    endtask
    task automatic tick;
        @(posedge clk);
        #3;
    endtask
    task automatic push_rd(input int k, input logic [PW-1:0] p);
        if (k == 0) rq0.push_back(p); else rq1.push_back(p);
        ep.push_back('{idx: k, val: DW'(p)});
        for (int i = 0; i < B; i++) er.push_back('{idx: k, val: rdat(p, i)});
    endtask
    task automatic wait_done(input string nm, input int lim);
        int n;
        logic pb;
        n = 0;
        pb = 1'b0;
        while ((ep.size() + er.size() + ew.size()) > 0 && n < lim) begin
            pb = busy;
            tick;
            n++;
        end
        chk({nm, "_timeout"}, 128'(n >= lim), 0);
        chk({nm, "_busy_last_beat"}, pb, 1);
        chk({nm, "_busy_after"}, busy, 0);
    endtask
    // requester and controller models: sample handshakes at negedge, update drives just after posedge
    initial begin
        logic a0, a1, w0, w1, c, rp;
        logic [PW-1:0] p;
        pkt_r = '0; pkt_v_r = '0; rready_r = '1; wdata_r = '0; wdata_v_r = '0;
        ddata_in_r = '0; cq_v_r = 1'b0; stray_r = 1'b0; wtog = 1'b0; rtog = 1'b0;
        forever begin
            @(negedge clk);
            a0 = pkt_v_r[0] & pkt_yumi[0];
            a1 = pkt_v_r[1] & pkt_yumi[1];
            w0 = wdata_v_r[0] & wyumi[0];
            w1 = wdata_v_r[1] & wyumi[1];
            c  = cq_v_r & dready;
            rp = dpkt_v & dpkt_yumi & ~dpkt[PW-1];
            p  = dpkt;
            @(posedge clk);
            #1;
            if (a0) void'(rq0.pop_front());
            if (a1) void'(rq1.pop_front());
            if (w0) void'(wq0.pop_front());
            if (w1) void'(wq1.pop_front());
            if (c) void'(cq.pop_front());
            if (rp) for (int i = 0; i < B; i++) cq.push_back(rdat(p, i));
            wtog = ~wtog;
            rtog = ~rtog;
            pkt_v_r   = {rq1.size() > 0, rq0.size() > 0};
            pkt_r     = {rq1.size() > 0 ? rq1[0] : PW'(0), rq0.size() > 0 ? rq0[0] : PW'(0)};
            wdata_v_r = {wq1.size() > 0, wq0.size() > 0};
            wdata_r   = {wq1.size() > 0 ? wq1[0] : DW'(0), wq0.size() > 0 ? wq0[0] : DW'(0)};
            cq_v_r    = cq.size() > 0;
            ddata_in_r = cq.size() > 0 ? cq[0] : DW'(0);
            rready_r  = {rtog, 1'b1};
        end
    end
    always @(negedge clk) begin
        exp_t e;
        if (dpkt_v && dpkt_yumi) begin
            if (ep.size() == 0) extra("pkt_extra");
            else begin
                e = ep.pop_front();
                chk("pkt", 128'(dpkt), 128'(e.val[PW-1:0]));
                chk("pkt_yumi", 128'(pkt_yumi), 128'(oh(e.idx)));
            end
        end
        if (ddata_v_out && dyumi) begin
            if (ew.size() == 0) extra("wdata_extra");
            else begin
                e = ew.pop_front();
                chk("wdata", 128'(ddata_out), 128'(e.val));
                chk("wdata_yumi", 128'(wyumi), 128'(oh(e.idx)));
            end
        end
        if (ddata_v_in && dready) begin
            if (er.size() == 0) extra("rdata_extra");
            else begin
                e = er.pop_front();
                chk("rdata", rdata, {2{e.val}});
                chk("rdata_v", 128'(rdata_v), 128'(oh(e.idx)));
            end
        end
        if (s_dpkt_v && s_dpkt_yumi) begin
            if (se.size() == 0) extra("s_pkt_extra");
            else begin
                e = se.pop_front();
                chk("s_kind_pkt", 128'(e.idx), 0);
                chk("s_pkt", 128'(s_dpkt), 128'(e.val[PW-1:0]));
                chk("s_pkt_yumi", 128'(s_pkt_yumi), 2'b10);
            end
        end
        if (s_ddata_v_in && s_dready) begin
            if (se.size() == 0) extra("s_rdata_extra");
            else begin
                e = se.pop_front();
                chk("s_kind_rd", 128'(e.idx), 1);
                chk("s_rdata", 128'(s_rdata[2*DW-1:DW]), 128'(e.val));
                chk("s_rdata_v", 128'(s_rdata_v), 2'b10);
            end
        end
        if (s_ddata_v_out && s_dyumi) begin
            if (se.size() == 0) extra("s_wdata_extra");
            else begin
                e = se.pop_front();
                chk("s_kind_wr", 128'(e.idx), 2);
                chk("s_wdata", 128'(s_ddata_out), 128'(e.val));
                chk("s_wyumi", 128'(s_wyumi), 2'b10);
            end
        end
    end
    initial begin
        #300000;
        $display("FAIL watchdog got=no-finish want=finish");
        $fatal(1);
    end
    initial begin
        logic seen_v, seen_r;
        logic [PW-1:0] p, rd, wr;
        int n;
        reset_r = 1'b1;
        calib_r = 1'bx;
        s_pkt = '0;
        s_pkt_v = '0;
        repeat (3) tick;
        @(negedge clk);
        chk("reset_outs", {busy, dpkt_v, ddata_v_out, dready, pkt_yumi, wyumi, rdata_v}, 0);
        tick;
        reset_r = 1'b0;
        calib_r = 1'b0;
        @(negedge clk);
        chk("post_reset_outs", {busy, dpkt_v, ddata_v_out, dready, pkt_yumi, wyumi, rdata_v}, 0);
        // calibration gating, with stray downstream read data while idle
        tick;
        push_rd(0, mk(1'b0, 32'h40));
        stray_r = 1'b1;
        seen_v = 1'b0;
        seen_r = 1'b0;
        repeat (20) begin
            @(negedge clk);
            seen_v |= dpkt_v;
            seen_r |= dready;
        end
        chk("calib_gate_pkt_v", seen_v, 0);
        chk("stray_ready", seen_r, 0);
        tick;
        stray_r = 1'b0;
        calib_r = 1'b1;
        @(negedge clk);
        chk("calib_pkt_v_arb_cycle", dpkt_v, 0);
        @(negedge clk);
        chk("calib_pkt_v_after", dpkt_v, 1);
        wait_done("calib_rd", 100);
        // single read from requester 1 with toggling ready
        tick;
        push_rd(1, mk(1'b0, 32'h1000));
        wait_done("read1", 200);
        // fairness: both hold reads, pointer starts at 0
        tick;
        push_rd(0, mk(1'b0, 32'h2000));
        push_rd(1, mk(1'b0, 32'h3000));
        push_rd(0, mk(1'b0, 32'h2040));
        push_rd(1, mk(1'b0, 32'h3040));
        wait_done("fair", 400);
        // single write from requester 0, controller yumi every other cycle
        tick;
        p = mk(1'b1, 32'h4000);
        rq0.push_back(p);
        ep.push_back('{idx: 0, val: DW'(p)});
        for (int i = 0; i < B; i++) begin
            wq0.push_back(DW'(8'ha0 + i));
            ew.push_back('{idx: 0, val: DW'(8'ha0 + i)});
        end
        wait_done("write0", 200);
        // reset after beat 3 of a write
        tick;
        p = mk(1'b1, 32'h5000);
        rq1.push_back(p);
        ep.push_back('{idx: 1, val: DW'(p)});
        for (int i = 0; i < B; i++) wq1.push_back(DW'(8'hb0 + i));
        for (int i = 0; i < 4; i++) ew.push_back('{idx: 1, val: DW'(8'hb0 + i)});
        n = 0;
        while (ew.size() > 0 && n < 200) begin
            tick;
            n++;
        end
        chk("midrst_timeout", 128'(n >= 200), 0);
        reset_r = 1'b1;
        @(negedge clk);
        chk("midrst_outs", {busy, dpkt_v, ddata_v_out, dready, pkt_yumi, wyumi, rdata_v}, 0);
        tick;
        reset_r = 1'b0;
        wq1.delete();
        @(negedge clk);
        chk("midrst_after_outs", {busy, dpkt_v, ddata_v_out, dready, pkt_yumi, wyumi, rdata_v}, 0);
        tick;
        p = mk(1'b1, 32'h6000);
        rq1.push_back(p);
        ep.push_back('{idx: 1, val: DW'(p)});
        for (int i = 0; i < B; i++) begin
            wq1.push_back(DW'(8'hc0 + i));
            ew.push_back('{idx: 1, val: DW'(8'hc0 + i)});
        end
        wait_done("post_rst_write", 200);
        // beats_p=1 instance: back-to-back read then write from requester 1
        rd = mk(1'b0, 32'h7000);
        wr = mk(1'b1, 32'h7040);
        se.push_back('{idx: 0, val: DW'(rd)});
        se.push_back('{idx: 1, val: 64'h5a5a});
        se.push_back('{idx: 0, val: DW'(wr)});
        se.push_back('{idx: 2, val: 64'hbeef_0001});
        tick;
        s_pkt = {rd, PW'(0)};
        s_pkt_v = 2'b10;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!s_pkt_yumi[1] && n < 20);
        chk("s_rd_pkt_timeout", 128'(n >= 20), 0);
        @(posedge clk);
        #1;
        s_pkt = {wr, PW'(0)};
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(s_dready && s_ddata_v_in) && n < 20);
        chk("s_rd_beat_timeout", 128'(n >= 20), 0);
        @(negedge clk);
        chk("s_idle_gap", {s_busy, s_dpkt_v}, 0);
        @(negedge clk);
        chk("s_wr_pkt_next", s_dpkt_v, 1);
        @(posedge clk);
        #1;
        s_pkt_v = 2'b00;
        repeat (3) tick;
        chk("s_all_seen", 128'(se.size()), 0);
        chk("s_busy_end", s_busy, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
